// File: rtl/systolic_feeder.sv
// Upstream feeder for the 3x3 systolic array: buffers activation vectors,
// then streams them into the array rows with a one-cycle-per-row diagonal skew.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | accepting vectors into the buffer, waiting for go
// STREAM | issuing skewed elements, N+2 cycles (t = 0..N+1)
// DONE   | one-cycle completion pulse; buffer count clears on exit
module systolic_feeder #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vec_valid,
   output logic              vec_ready,
   input  logic [DATA_W-1:0] vec_in_1,
   input  logic [DATA_W-1:0] vec_in_2,
   input  logic [DATA_W-1:0] vec_in_3,
   input  logic              go,
   output logic              busy,
   output logic [CNT_W-1:0]  count,
   output logic              start_out,
   output logic [DATA_W-1:0] input_11,
   output logic [DATA_W-1:0] input_21,
   output logic [DATA_W-1:0] input_31,
   output logic              done
);

   // stream index must reach DEPTH+1, one bit wider than the count
   localparam int TW = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TW-1:0]       t_q, t_d;
   logic [DATA_W-1:0]   in_q [3];
   logic [DATA_W-1:0]   in_d [3];
   logic [DATA_W-1:0]   buf_q [DEPTH][3];
   logic [DATA_W-1:0]   rd [DEPTH][3];
   logic [DATA_W-1:0]   vin [3];
   logic                accept;
   logic [CNT_W-1:0]    count_eff;
   logic                issue;
   logic [TW-1:0]       t_nx;
   logic [CNT_W-1:0]    n_sel;

   assign vin[0] = vec_in_1;
   assign vin[1] = vec_in_2;
   assign vin[2] = vec_in_3;

   assign vec_ready = !rst && (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH));
   assign accept    = vec_valid && vec_ready;
   assign count_eff = count_q + CNT_W'(accept);

   // buffer read view; a beat landing on the go cycle is forwarded straight from the inputs
   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         for (int r = 0; r < 3; r++) begin
            rd[j][r] = (accept && (count_q == CNT_W'(j))) ? vin[r] : buf_q[j][r];
         end
      end
   end

   // next-state, stream index and next registered array inputs
   always_comb begin
      state_d = state_q;
      count_d = accept ? (count_q + CNT_W'(1)) : count_q;
      t_d     = t_q;
      issue   = 1'b0;
      t_nx    = '0;
      n_sel   = count_q;
      case (state_q)
         S_IDLE: begin
            if (go && (count_eff != '0)) begin
               state_d = S_STREAM;
               t_d     = '0;
               issue   = 1'b1;
               t_nx    = '0;
               n_sel   = count_eff;
            end
         end
         S_STREAM: begin
            if (t_q == ({1'b0, count_q} + TW'(1))) begin
               state_d = S_DONE;
            end else begin
               t_d   = t_q + TW'(1);
               issue = 1'b1;
               t_nx  = t_q + TW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            count_d = '0;
            t_d     = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      for (int r = 0; r < 3; r++) begin
         in_d[r] = '0;
         if (issue) begin
            for (int j = 0; j < DEPTH; j++) begin
               if ((t_nx >= TW'(r)) && ((t_nx - TW'(r)) == TW'(j)) &&
                   (TW'(j) < {1'b0, n_sel})) begin
                  in_d[r] = rd[j][r];
               end
            end
         end
      end
   end

   // control and array-facing registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         t_q     <= '0;
         for (int r = 0; r < 3; r++) in_q[r] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         t_q     <= t_d;
         for (int r = 0; r < 3; r++) in_q[r] <= in_d[r];
      end
   end

   // vector storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (count_q == CNT_W'(j)) begin
               for (int r = 0; r < 3; r++) buf_q[j][r] <= vin[r];
            end
         end
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign start_out = (state_q == S_STREAM);
   assign done      = (state_q == S_DONE);
   assign count     = count_q;
   assign input_11  = in_q[0];
   assign input_21  = in_q[1];
   assign input_31  = in_q[2];

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the 3x3 systolic array.
- Buffers up to DEPTH activation vectors, each with three 16-bit elements (one per array row).
- On go, streams the vectors into the array's row inputs with diagonal skew: row r is delayed r-1 cycles, so partial sums meet the matching activation as they flow down.
- Drives the array's start and reports completion.

Parameters:
DATA_W, 16, width of each activation element.
DEPTH, 4, maximum number of vectors buffered per run (>=1).
CNT_W, $clog2(DEPTH+1), width of count and stream counters.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
vec_valid  in  1  upstream has a vector on vec_in_1..3.
vec_ready  out  1  feeder can accept a vector this cycle.
vec_in_1  in  DATA_W  element for array row 1.
vec_in_2  in  DATA_W  element for array row 2.
vec_in_3  in  DATA_W  element for array row 3.
go  in  1  single-cycle request to stream buffered vectors.
busy  out  1  high in STREAM and DONE states.
count  out  CNT_W  number of vectors currently buffered.
start_out  out  1  to array start; high for every STREAM cycle.
input_11  out  DATA_W  to array row 1 input.
input_21  out  DATA_W  to array row 2 input.
input_31  out  DATA_W  to array row 3 input.
done  out  1  one-cycle pulse after the last skewed element is issued.

Behaviour:
- Clocking and reset: single clock clk; reset rst is asynchronous and active-high.
- While rst is high:
  - State is IDLE, count=0, stream counter=0.
  - busy=0, start_out=0, done=0, input_11/21/31=0.
  - vec_ready=0.
  - Buffer contents are don't-care.
- vec_ready is combinational: !rst && state==IDLE && count<DEPTH.
- Load: a beat is accepted when vec_valid && vec_ready. The vector is written to buf[count] and count increments on that edge. vec_valid while vec_ready=0 is ignored; no beat is taken.
- State machine:
  - IDLE -> STREAM on go when the effective N > 0.
    - Effective N = count, plus 1 if a beat is accepted in the same cycle. The simultaneous beat is included as the last vector.
    - go with N=0 is ignored: no state change, no done.
  - STREAM lasts exactly N+2 cycles (N + rows - 1), indexed t=0..N+1.
  - STREAM -> DONE after t=N+1.
  - DONE lasts one cycle, then -> IDLE.
- All array-facing outputs are registered. Values for t=0 appear on the edge that enters STREAM.
- During STREAM cycle t, for row r in 1..3, let k = t-(r-1):
  - input_r1 = buf[k][r] if 0 <= k < N, else 0.
  - start_out=1, busy=1, vec_ready=0.
- go is ignored in STREAM and DONE.
- DONE cycle: done=1, start_out=0, inputs=0, busy=1. count clears to 0 on exit, so buffered data is consumed.
- Data is passed through unmodified; there is no arithmetic or sign handling.
- Reset asserted mid-STREAM or mid-load: outputs clear immediately (asynchronously), buffered vectors are discarded, no done pulse. After rst falls, the block is in IDLE with count=0.
- Buffer full (count=DEPTH): vec_ready=0. go still starts the stream with N=DEPTH.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately. After release: vec_ready=1, count=0, state IDLE.
- Basic stream: load (1,2,3), (4,5,6), (7,8,9), then pulse go. Over STREAM cycles t0..t4:
  - input_11 = 1,4,7,0,0
  - input_21 = 0,2,5,8,0
  - input_31 = 0,0,3,6,9
  - start_out high exactly 5 cycles; done high the next cycle; count=0 afterwards.
- Full buffer: hold vec_valid for 5 beats of values 10..14 -> only 4 accepted, vec_ready=0 after the 4th, count=4. After go, STREAM lasts 6 cycles and input_31 last non-zero = element 3 of the 4th vector.
- Edge handshakes:
  - go with count=0 -> no STREAM, no done.
  - go in the same cycle as the 2nd accepted beat -> N=2, STREAM lasts 4 cycles, with the 2nd vector issued last.
- Single vector (5,6,7), N=1 -> input_11 = 5,0,0; input_21 = 0,6,0; input_31 = 0,0,7; 3 STREAM cycles, then done.
- Reset at t=2 of a 3-vector stream -> outputs 0 asynchronously, no done pulse, count=0. A fresh load/go afterwards streams correctly.
